// File: rtl/spi_register_bank.sv
// Bank of REGISTER_COUNT multi-byte read/write registers on the SPI subperipheral bus.
// Optional hardware status word at BASE+2*COUNT: define SPI_REGISTER_BANK_STATUS_EN.
module spi_register_bank #(
  parameter logic [7:0]                  BASE_ADDRESS   = 8'hB0,
  parameter int unsigned                 REGISTER_COUNT = 4,
  parameter int unsigned                 REGISTER_BYTES = 4,
  parameter logic [REGISTER_BYTES*8-1:0] RESET_VALUE    = '0
) (
  input  logic                                       system_clock,
  input  logic                                       system_reset,
  input  logic [7:0]                                 address_in,
  input  logic                                       address_in_valid,
  input  logic [7:0]                                 data_in,
  input  logic                                       data_in_valid,
  output logic [7:0]                                 data_out,
  output logic                                       data_out_valid,
  output logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] register_values_out,
  output logic [REGISTER_COUNT-1:0]                  register_write_strobe_out
`ifdef SPI_REGISTER_BANK_STATUS_EN
  ,
  input  logic [REGISTER_BYTES*8-1:0]                status_in
`endif
);

  localparam int unsigned RegW = REGISTER_BYTES * 8;
  localparam int unsigned PtrW = (REGISTER_BYTES > 1) ? $clog2(REGISTER_BYTES) : 1;
  localparam int unsigned SelW = $clog2(REGISTER_COUNT + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(REGISTER_BYTES - 1);
  localparam logic [8:0]      ReadLo  = {1'b0, BASE_ADDRESS};
  localparam logic [8:0]      ReadHi  = ReadLo + 9'(REGISTER_COUNT);
  localparam logic [8:0]      WriteHi = ReadLo + 9'(2 * REGISTER_COUNT);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     ptr_q;
  logic [SelW-1:0]     sel_q;
  logic [7:0]          addr_q;
  logic [RegW-1:0]     shadow_q;
  logic [7:0]          data_out_q;
  logic                data_out_valid_q;
  logic [REGISTER_COUNT-1:0] strobe_q;
  logic [RegW-1:0]     regs_q [REGISTER_COUNT];
`ifdef SPI_REGISTER_BANK_STATUS_EN
  logic [RegW-1:0]     status_q;
`endif

  logic [8:0]      addr_ext;
  logic            read_hit;
  logic            write_hit;
  logic [SelW-1:0] hit_sel;
  logic [RegW-1:0] read_word;
  logic [RegW-1:0] shadow_d;
  logic [7:0]      read_byte;
  int              ptr_lsb;

  // Address decode on the live bus address.
  always_comb begin
    addr_ext  = {1'b0, address_in};
    read_hit  = (addr_ext >= ReadLo) && (addr_ext < ReadHi);
    write_hit = (addr_ext >= ReadHi) && (addr_ext < WriteHi);
    hit_sel   = read_hit ? SelW'(address_in - BASE_ADDRESS)
                         : SelW'(address_in - BASE_ADDRESS - 8'(REGISTER_COUNT));
`ifdef SPI_REGISTER_BANK_STATUS_EN
    if (addr_ext == WriteHi) begin
      read_hit = 1'b1;
      hit_sel  = SelW'(REGISTER_COUNT);
    end
`endif
  end

  // Byte 0 is the most significant byte of a word.
  always_comb begin
    ptr_lsb = int'(RegW) - 8 - 8 * int'(ptr_q);
    read_word = '0;
    for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
      if (sel_q == SelW'(i)) read_word = regs_q[i];
    end
`ifdef SPI_REGISTER_BANK_STATUS_EN
    if (sel_q == SelW'(REGISTER_COUNT)) read_word = status_q;
`endif
    read_byte = read_word[ptr_lsb +: 8];
    shadow_d = shadow_q;
    shadow_d[ptr_lsb +: 8] = data_in;
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q          <= StIdle;
      ptr_q            <= '0;
      sel_q            <= '0;
      addr_q           <= '0;
      shadow_q         <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      strobe_q         <= '0;
      for (int unsigned i = 0; i < REGISTER_COUNT; i++) regs_q[i] <= RESET_VALUE;
`ifdef SPI_REGISTER_BANK_STATUS_EN
      status_q         <= '0;
`endif
    end else begin
      strobe_q <= '0;
      if (state_q != StIdle && (!address_in_valid || address_in != addr_q)) begin
        // Transaction ended or re-addressed: drop any partial word.
        state_q          <= StIdle;
        data_out_q       <= '0;
        data_out_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (address_in_valid) begin
              addr_q   <= address_in;
              ptr_q    <= '0;
              sel_q    <= hit_sel;
              shadow_q <= '0;
              data_out_q <= '0;
`ifdef SPI_REGISTER_BANK_STATUS_EN
              status_q <= status_in;
`endif
              if (read_hit) begin
                state_q          <= StRead;
                data_out_valid_q <= 1'b1;
              end else if (write_hit) begin
                state_q          <= StWrite;
                data_out_valid_q <= 1'b1;
              end else begin
                state_q          <= StDone;
                data_out_valid_q <= 1'b0;
              end
            end
          end
          StRead: begin
            data_out_q <= read_byte;
            if (data_in_valid) ptr_q <= (ptr_q == LastPtr) ? '0 : ptr_q + PtrW'(1);
          end
          StWrite: begin
            data_out_q <= '0;
            if (data_in_valid) begin
              shadow_q <= shadow_d;
              if (ptr_q == LastPtr) begin
                ptr_q <= '0;
                for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
                  if (sel_q == SelW'(i)) begin
                    regs_q[i]   <= shadow_d;
                    strobe_q[i] <= 1'b1;
                  end
                end
              end else begin
                ptr_q <= ptr_q + PtrW'(1);
              end
            end
          end
          StDone: begin
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    register_values_out = '0;
    for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
      register_values_out[i*RegW +: RegW] = regs_q[i];
    end
  end

  assign data_out                  = data_out_q;
  assign data_out_valid            = data_out_valid_q;
  assign register_write_strobe_out = strobe_q;

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed self-checking bench for spi_register_bank (default 4 x 32-bit bank at 0xB0).
module tb_spi_register_bank;

  logic         system_clock;
  logic         system_reset;
  logic [7:0]   address_in;
  logic         address_in_valid;
  logic [7:0]   data_in;
  logic         data_in_valid;
  logic [7:0]   data_out;
  logic         data_out_valid;
  logic [127:0] register_values_out;
  logic [3:0]   register_write_strobe_out;
`ifdef SPI_REGISTER_BANK_STATUS_EN
  logic [31:0]  status_in;
`endif

  spi_register_bank #(
    .BASE_ADDRESS   (8'hB0),
    .REGISTER_COUNT (4),
    .REGISTER_BYTES (4),
    .RESET_VALUE    (32'h0)
  ) dut (
    .system_clock              (system_clock),
    .system_reset              (system_reset),
    .address_in                (address_in),
    .address_in_valid          (address_in_valid),
    .data_in                   (data_in),
    .data_in_valid             (data_in_valid),
    .data_out                  (data_out),
    .data_out_valid            (data_out_valid),
    .register_values_out       (register_values_out),
    .register_write_strobe_out (register_write_strobe_out)
`ifdef SPI_REGISTER_BANK_STATUS_EN
    ,
    .status_in                 (status_in)
`endif
  );

  initial system_clock = 1'b0;
  always #10 system_clock = ~system_clock;

  int n_vec  = 0;
  int n_miss = 0;
  int hi_cnt   [4] = '{default: 0};
  int base_cnt [4] = '{default: 0};

  // Strobe-high cycles per register, sampled at the active edge.
  always @(posedge system_clock) begin
    for (int i = 0; i < 4; i++) if (register_write_strobe_out[i]) hi_cnt[i]++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return register_values_out[i*32 +: 32];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  task automatic snap();
    base_cnt = hi_cnt;
  endtask

  // exp holds the expected pulse count for register i in nibble i.
  task automatic check_strobes(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s_stb%0d", tag, i), 64'(hi_cnt[i] - base_cnt[i]), 64'(exp[i*4 +: 4]));
  endtask

  task automatic start(input logic [7:0] addr);
    address_in       = addr;
    address_in_valid = 1'b1;
    tick(2);
  endtask

  task automatic stop();
    address_in_valid = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in       = b;
    data_in_valid = 1'b1;
    tick(1);
    data_in_valid = 1'b0;
    tick(2);
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [31:0] w);
    start(addr);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    stop();
  endtask

  task automatic read_expect(input string tag, input logic [7:0] addr, input logic [31:0] w,
                             input int nbytes);
    start(addr);
    check_eq({tag, "_valid"}, 64'(data_out_valid), 64'd1);
    for (int k = 0; k < nbytes; k++) begin
      check_eq($sformatf("%s_b%0d", tag, k), 64'(data_out), 64'(w[31-8*(k%4) -: 8]));
      send_byte(8'h5A);
    end
    stop();
  endtask

  initial begin
    system_reset     = 1'b1;
    address_in       = 8'h00;
    address_in_valid = 1'b0;
    data_in          = 8'h00;
    data_in_valid    = 1'b0;
`ifdef SPI_REGISTER_BANK_STATUS_EN
    status_in        = 32'h0;
`endif
    tick(3);
    system_reset = 1'b0;
    tick(1);

    check_eq("rst_dout", 64'(data_out), 64'h0);
    check_eq("rst_valid", 64'(data_out_valid), 64'h0);
    check_eq("rst_strobe", 64'(register_write_strobe_out), 64'h0);
    check_eq("rst_regs", 64'(register_values_out[63:0] | register_values_out[127:64]), 64'h0);

    // Read of a reset register.
    snap();
    read_expect("rd_b1", 8'hB1, 32'h0000_0000, 4);
    check_eq("rd_b1_idle", 64'(data_out_valid), 64'h0);
    check_strobes("rd_b1", 16'h0000);

    // Full write to register 2, checking the commit cycle exactly.
    snap();
    start(8'hB6);
    check_eq("wr_b6_valid", 64'(data_out_valid), 64'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    check_eq("wr_b6_pre", 64'(reg_word(2)), 64'h0);
    check_eq("wr_b6_dout", 64'(data_out), 64'h0);
    data_in = 8'h78;
    data_in_valid = 1'b1;
    tick(1);
    data_in_valid = 1'b0;
    check_eq("wr_b6_reg", 64'(reg_word(2)), 64'h1234_5678);
    check_eq("wr_b6_stb_on", 64'(register_write_strobe_out), 64'h4);
    tick(1);
    check_eq("wr_b6_stb_off", 64'(register_write_strobe_out), 64'h0);
    tick(1);
    stop();
    check_strobes("wr_b6", 16'h0100);
    check_eq("wr_b6_others", 64'(reg_word(0) | reg_word(1) | reg_word(3)), 64'h0);
    read_expect("rd_b2", 8'hB2, 32'h1234_5678, 5);

    // Partial write is discarded; the next write restarts at byte 0.
    snap();
    start(8'hB4);
    send_byte(8'hAA);
    send_byte(8'hBB);
    stop();
    check_eq("part_reg0", 64'(reg_word(0)), 64'h0);
    check_strobes("part", 16'h0000);
    write_word(8'hB4, 32'h0102_0304);
    check_eq("wr_b4_reg0", 64'(reg_word(0)), 64'h0102_0304);

    // Two-word burst commits twice.
    snap();
    start(8'hB7);
    for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k));
    check_eq("burst_mid", 64'(reg_word(3)), 64'h1112_1314);
    for (int k = 4; k < 8; k++) send_byte(8'h11 + 8'(k));
    stop();
    check_eq("burst_reg3", 64'(reg_word(3)), 64'h1516_1718);
    check_strobes("burst", 16'h2000);

    // Address change mid-write abandons it and re-decodes as a read of register 1.
    write_word(8'hB5, 32'hA1B2_C3D4);
    snap();
    start(8'hB5);
    send_byte(8'hEE);
    send_byte(8'hFF);
    address_in = 8'hB1;
    tick(3);
    check_eq("chg_valid", 64'(data_out_valid), 64'd1);
    check_eq("chg_dout", 64'(data_out), 64'hA1);
    check_eq("chg_reg1", 64'(reg_word(1)), 64'hA1B2_C3D4);
    stop();
    check_strobes("chg", 16'h0000);

    // Data byte coincident with address_in_valid falling is ignored.
    snap();
    start(8'hB4);
    send_byte(8'h09);
    send_byte(8'h08);
    send_byte(8'h07);
    data_in = 8'h06;
    data_in_valid = 1'b1;
    address_in_valid = 1'b0;
    tick(1);
    data_in_valid = 1'b0;
    tick(2);
    check_eq("fall_reg0", 64'(reg_word(0)), 64'h0102_0304);
    check_strobes("fall", 16'h0000);

    // Reset on the final write byte wins over the commit.
    snap();
    start(8'hB5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    data_in = 8'h04;
    data_in_valid = 1'b1;
    system_reset = 1'b1;
    tick(1);
    check_eq("rstc_reg1", 64'(reg_word(1)), 64'h0);
    check_eq("rstc_reg2", 64'(reg_word(2)), 64'h0);
    check_eq("rstc_stb", 64'(register_write_strobe_out), 64'h0);
    check_eq("rstc_valid", 64'(data_out_valid), 64'h0);
    system_reset = 1'b0;
    data_in_valid = 1'b0;
    address_in_valid = 1'b0;
    tick(2);
    check_strobes("rstc", 16'h0000);

    // Out-of-range address stays silent.
    start(8'hA0);
    check_eq("miss_a0_valid", 64'(data_out_valid), 64'h0);
    send_byte(8'h33);
    check_eq("miss_a0_valid2", 64'(data_out_valid), 64'h0);
    check_eq("miss_a0_dout", 64'(data_out), 64'h0);
    stop();

`ifdef SPI_REGISTER_BANK_STATUS_EN
    // Status word is snapshotted at accept.
    status_in = 32'hCAFE_F00D;
    start(8'hB8);
    check_eq("st_valid", 64'(data_out_valid), 64'd1);
    check_eq("st_b0", 64'(data_out), 64'hCA);
    send_byte(8'h00);
    status_in = 32'h0;
    check_eq("st_b1", 64'(data_out), 64'hFE);
    send_byte(8'h00);
    check_eq("st_b2", 64'(data_out), 64'hF0);
    send_byte(8'h00);
    check_eq("st_b3", 64'(data_out), 64'h0D);
    send_byte(8'h00);
    stop();
    snap();
    start(8'hB8);
    for (int k = 0; k < 4; k++) send_byte(8'h77);
    stop();
    check_strobes("st_wr", 16'h0000);
    check_eq("st_wr_regs", 64'(register_values_out[63:0] | register_values_out[127:64]), 64'h0);
`else
    start(8'hB8);
    check_eq("miss_b8_valid", 64'(data_out_valid), 64'h0);
    stop();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
